// File: rtl/pwm_shadow_commit_ctrl_pkg.sv
// Shared types and constants for the PWM shadow/commit controller.
package pwm_shadow_commit_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DONE  = 2'd2
  } commit_state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_TIMEOUT = 2'b01,
    ERR_BUSY    = 2'b10,
    ERR_ABORT   = 2'b11
  } commit_err_e;

  localparam logic WRSEL_PERIOD  = 1'b0;
  localparam logic WRSEL_COMPARE = 1'b1;

  // Width of a counter that must hold 0..timeout-1.
  function automatic int unsigned to_cnt_width(input int unsigned timeout);
    return (timeout < 2) ? 1 : $clog2(timeout);
  endfunction

endpackage

// File: rtl/pwm_shadow_commit_ctrl_shadow.sv
// One carrier's shadow period/compare pair and the active pair it feeds.
module shadow_reg_16bits
  import pwm_shadow_commit_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic             wr_sel,
  input  logic [CNT_W-1:0] wr_data,
  input  logic             load,
  output logic [CNT_W-1:0] period_c,
  output logic [CNT_W-1:0] compare_c
);

  logic [CNT_W-1:0] sh_period;
  logic [CNT_W-1:0] sh_compare;

  // Shadow pair: written by software, only while the controller accepts writes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sh_period  <= '0;
      sh_compare <= '0;
    end else if (wr_en) begin
      if (wr_sel == WRSEL_COMPARE) sh_compare <= wr_data;
      else                         sh_period  <= wr_data;
    end
  end

  // Active pair: copied from the shadow only on this carrier's update event.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      period_c  <= '0;
      compare_c <= '0;
    end else if (load) begin
      period_c  <= sh_period;
      compare_c <= sh_compare;
    end
  end

endmodule

// File: rtl/pwm_shadow_commit_ctrl.sv
// Double-buffered period/compare commit controller for the PWM carrier array.
// A commit arms a set of carriers; each one reloads on its own masked event.
module pwm_shadow_commit_ctrl
  import pwm_shadow_commit_ctrl_pkg::*;
#(
  parameter int N_CARR  = 8,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1048575
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [2:0]                    wr_carr,
  input  logic                          wr_sel,
  input  logic [CNT_W-1:0]              wr_data,
  input  logic                          commit_req,
  input  logic [N_CARR-1:0]             commit_mask,
  input  logic                          abort,
  input  logic [N_CARR-1:0]             update_event,
  output logic [N_CARR-1:0][CNT_W-1:0]  period_c,
  output logic [N_CARR-1:0][CNT_W-1:0]  compare_c,
  output logic [N_CARR-1:0]             pending,
  output logic                          busy,
  output logic                          commit_done,
  output logic [1:0]                    err
);

  localparam int unsigned          TO_W    = to_cnt_width(TIMEOUT);
  localparam logic [TO_W-1:0]      TO_LAST = TO_W'(TIMEOUT - 1);

  commit_state_e     state, state_nxt;
  commit_err_e       err_nxt;
  logic [N_CARR-1:0] pending_nxt;
  logic [N_CARR-1:0] remaining;
  logic [N_CARR-1:0] load;
  logic [N_CARR-1:0] wr_en;
  logic [TO_W-1:0]   cnt, cnt_nxt;

  assign wr_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  // Per-carrier shadow/active pairs; out-of-range carrier indices match no slot.
  for (genvar i = 0; i < N_CARR; i++) begin : g_carr
    assign wr_en[i] = wr_valid & wr_ready & (wr_carr == 3'(i));

    shadow_reg_16bits #(.CNT_W(CNT_W)) u_shadow (
      .clk       (clk),
      .reset     (reset),
      .wr_en     (wr_en[i]),
      .wr_sel    (wr_sel),
      .wr_data   (wr_data),
      .load      (load[i]),
      .period_c  (period_c[i]),
      .compare_c (compare_c[i])
    );
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state, loads and error code. In ARMED: abort beats completion, and
  // completion beats timeout so a late event still lands.
  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    cnt_nxt     = cnt;
    err_nxt     = ERR_NONE;
    load        = '0;
    remaining   = pending;
    case (state)
      IDLE: begin
        if (commit_req) begin
          if (|commit_mask) begin
            state_nxt   = ARMED;
            pending_nxt = commit_mask;
            cnt_nxt     = '0;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      ARMED: begin
        if (cnt != TO_LAST) cnt_nxt = cnt + 1'b1;
        if (abort) begin
          state_nxt   = IDLE;
          pending_nxt = '0;
          err_nxt     = ERR_ABORT;
        end else begin
          load        = pending & update_event;
          remaining   = pending & ~update_event;
          pending_nxt = remaining;
          if (remaining == '0) begin
            state_nxt = DONE;
          end else if (cnt == TO_LAST) begin
            state_nxt   = IDLE;
            pending_nxt = '0;
            err_nxt     = ERR_TIMEOUT;
          end
          if (commit_req && (err_nxt == ERR_NONE)) err_nxt = ERR_BUSY;
        end
      end
      DONE: begin
        state_nxt = IDLE;
        if (commit_req) err_nxt = ERR_BUSY;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Registered pending mask, timeout counter and status pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending     <= '0;
      cnt         <= '0;
      commit_done <= 1'b0;
      err         <= ERR_NONE;
    end else begin
      pending     <= pending_nxt;
      cnt         <= cnt_nxt;
      commit_done <= (state_nxt == DONE);
      err         <= err_nxt;
    end
  end

endmodule
